// File: rtl/mac_seq_pkg.sv
// Shared constants and state encoding for the neuron-layer MAC sequencer.
package mac_seq_pkg;

  localparam int DEF_DATA_WIDTH = 16;  // operand/result word width
  localparam int DEF_TAPS       = 8;   // products accumulated per neuron
  localparam int DEF_TAP_W      = 3;   // clog2(DEF_TAPS)
  localparam int DEF_NRN_W      = 4;   // neuron index width

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_FETCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_WRITE = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

endpackage

// File: rtl/mac_seq_addr.sv
// Tap/neuron counters and operand-memory address generation for mac_seq.
module mac_seq_addr
  import mac_seq_pkg::*;
#(
  parameter int TAPS  = DEF_TAPS,
  parameter int TAP_W = DEF_TAP_W,
  parameter int NRN_W = DEF_NRN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [NRN_W:0]         n_nrn,
  input  logic                   tap_clr,
  input  logic                   tap_inc,
  input  logic                   nrn_inc,
  output logic                   tap_last,
  output logic                   nrn_last,
  output logic [NRN_W-1:0]       nrn,
  output logic [TAP_W-1:0]       x_addr,
  output logic [NRN_W+TAP_W-1:0] w_addr
);

  logic [TAP_W-1:0] tap;
  logic [NRN_W:0]   n_lat;

  // Counter state: load restarts the layer at neuron 0 and latches the neuron count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap   <= {TAP_W{1'b0}};
      nrn   <= {NRN_W{1'b0}};
      n_lat <= {(NRN_W+1){1'b0}};
    end else if (load) begin
      tap   <= {TAP_W{1'b0}};
      nrn   <= {NRN_W{1'b0}};
      n_lat <= n_nrn;
    end else begin
      if (tap_clr) begin
        tap <= {TAP_W{1'b0}};
      end else if (tap_inc && !tap_last) begin
        // tap saturates at TAPS-1 even if an increment is requested there
        tap <= tap + TAP_W'(1);
      end
      if (nrn_inc) begin
        // wraps naturally at 2^NRN_W, so a full-size layer visits every neuron
        nrn <= nrn + NRN_W'(1);
      end
    end
  end

  assign tap_last = (tap == TAP_W'(TAPS - 1));
  // last neuron when nrn == n_nrn-1; widened so n_nrn = 2^NRN_W compares correctly
  assign nrn_last = ({1'b0, nrn} == (n_lat - (NRN_W+1)'(1)));
  assign x_addr   = tap;
  assign w_addr   = {nrn, tap};

endmodule

// File: rtl/mac_seq.sv
// Neuron-layer sequencer: fetches operands per tap, hands them to the shared
// MAC with a valid/ack handshake and writes one result word per neuron.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAPS       = DEF_TAPS,
  parameter int TAP_W      = DEF_TAP_W,
  parameter int NRN_W      = DEF_NRN_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NRN_W:0]         n_nrn,
  input  logic                   abort,
  output logic [TAP_W-1:0]       x_addr,
  output logic [NRN_W+TAP_W-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0]  x_data,
  input  logic [DATA_WIDTH-1:0]  w_data,
  output logic [DATA_WIDTH-1:0]  op_x,
  output logic [DATA_WIDTH-1:0]  op_w,
  output logic                   op_vld,
  input  logic                   op_ack,
  output logic                   mac_clr,
  input  logic                   mac_rdy,
  input  logic [DATA_WIDTH-1:0]  mac_out,
  output logic                   res_we,
  output logic [NRN_W-1:0]       res_addr,
  output logic [DATA_WIDTH-1:0]  res_data,
  output logic                   busy,
  output logic                   done
);

  state_t           state;
  state_t           next_state;
  logic             load;
  logic             tap_clr;
  logic             tap_inc;
  logic             nrn_inc;
  logic             abort_hit;
  logic             tap_last;
  logic             nrn_last;
  logic [NRN_W-1:0] nrn;

  mac_seq_addr #(
    .TAPS  (TAPS),
    .TAP_W (TAP_W),
    .NRN_W (NRN_W)
  ) u_addr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .n_nrn    (n_nrn),
    .tap_clr  (tap_clr),
    .tap_inc  (tap_inc),
    .nrn_inc  (nrn_inc),
    .tap_last (tap_last),
    .nrn_last (nrn_last),
    .nrn      (nrn),
    .x_addr   (x_addr),
    .w_addr   (w_addr)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and counter-control decode; abort overrides everything outside IDLE/DONE
  always_comb begin
    next_state = state;
    load       = DISABLE;
    tap_clr    = DISABLE;
    tap_inc    = DISABLE;
    nrn_inc    = DISABLE;
    abort_hit  = DISABLE;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load = ENABLE;
          if (n_nrn == (NRN_W+1)'(0)) begin
            next_state = ST_DONE;
          end else begin
            next_state = ST_CLR;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_CLR: begin
        tap_clr    = ENABLE;
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (op_ack) begin
          if (tap_last) begin
            next_state = ST_DRAIN;
          end else begin
            tap_inc    = ENABLE;
            next_state = ST_FETCH;
          end
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        if (mac_rdy) begin
          next_state = ST_WRITE;
        end else begin
          next_state = ST_DRAIN;
        end
      end
      ST_WRITE: begin
        nrn_inc = ENABLE;
        if (nrn_last) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_CLR;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
    // DONE is already on its way out, so an abort there would only duplicate the done pulse
    if (abort && (state != ST_IDLE) && (state != ST_DONE)) begin
      abort_hit  = ENABLE;
      next_state = ST_DONE;
      tap_clr    = DISABLE;
      tap_inc    = DISABLE;
      nrn_inc    = DISABLE;
    end else begin
      abort_hit  = DISABLE;
    end
  end

  // Registered outputs toward the MAC, the result buffer and the layer top level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_x     <= {DATA_WIDTH{1'b0}};
      op_w     <= {DATA_WIDTH{1'b0}};
      op_vld   <= DISABLE;
      mac_clr  <= DISABLE;
      res_we   <= DISABLE;
      res_addr <= {NRN_W{1'b0}};
      res_data <= {DATA_WIDTH{1'b0}};
      busy     <= DISABLE;
      done     <= DISABLE;
    end else begin
      // clear pulse lines up with the CLR state, or follows an abort to flush partial sums
      mac_clr <= abort_hit | (next_state == ST_CLR);
      busy    <= (next_state != ST_IDLE);
      done    <= (state == ST_DONE);
      res_we  <= DISABLE;
      if (abort_hit) begin
        op_vld <= DISABLE;
      end else if (state == ST_ISSUE) begin
        // memory data is valid now, one cycle after the FETCH address
        op_x   <= x_data;
        op_w   <= w_data;
        op_vld <= ENABLE;
      end else if ((state == ST_WAIT) && op_ack) begin
        op_vld <= DISABLE;
      end
      if (!abort_hit && (state == ST_DRAIN) && mac_rdy) begin
        res_we   <= ENABLE;
        res_data <= mac_out;
        res_addr <= nrn;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// Randomized scoreboard bench for mac_seq with a behavioural MAC and operand memories.
module tb_mac_seq;

  localparam int DW = 16;
  localparam int TP = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [4:0]    n_nrn;
  logic          abort;
  logic [2:0]    x_addr;
  logic [6:0]    w_addr;
  logic [DW-1:0] x_data;
  logic [DW-1:0] w_data;
  logic [DW-1:0] op_x;
  logic [DW-1:0] op_w;
  logic          op_vld;
  logic          op_ack;
  logic          mac_clr;
  logic          mac_rdy;
  logic [DW-1:0] mac_out;
  logic          res_we;
  logic [3:0]    res_addr;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          done;

  mac_seq dut (
    .clk(clk), .reset(reset), .start(start), .n_nrn(n_nrn), .abort(abort),
    .x_addr(x_addr), .w_addr(w_addr), .x_data(x_data), .w_data(w_data),
    .op_x(op_x), .op_w(op_w), .op_vld(op_vld), .op_ack(op_ack),
    .mac_clr(mac_clr), .mac_rdy(mac_rdy), .mac_out(mac_out),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // operand memories and MAC environment
  logic [DW-1:0] x_mem [0:7];
  logic [DW-1:0] w_mem [0:127];
  logic [DW-1:0] acc;
  int            cnt;
  int            dly_cnt;
  int            drain_dly;
  logic          rdy_r;
  logic          rdy_inj;
  bit            ack_rand;
  bit            have_d;
  int            d;

  always @(posedge clk) begin
    x_data <= x_mem[x_addr];
    w_data <= w_mem[w_addr];
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0; cnt <= 0; dly_cnt <= 0; rdy_r <= 1'b0;
    end else if (mac_clr) begin
      acc <= '0; cnt <= 0; dly_cnt <= 0; rdy_r <= 1'b0;
    end else begin
      if (op_vld && op_ack) begin
        acc <= acc + 16'(op_x * op_w);
        cnt <= cnt + 1;
      end
      if (cnt == TP && !rdy_r) begin
        if (dly_cnt >= drain_dly) rdy_r <= 1'b1;
        else dly_cnt <= dly_cnt + 1;
      end
    end
  end

  assign mac_rdy = rdy_r | rdy_inj;
  assign mac_out = acc;

  // acknowledge driver: tied high, or a random 0..3 cycle delay per offered operand pair
  always @(posedge clk) begin
    #1;
    if (!ack_rand) begin
      op_ack = 1'b1;
    end else if (op_vld) begin
      if (!have_d) begin d = $urandom_range(0, 3); have_d = 1'b1; end
      if (d == 0) begin op_ack = 1'b1; have_d = 1'b0; end
      else begin op_ack = 1'b0; d = d - 1; end
    end else begin
      op_ack = 1'($urandom_range(0, 1));
      have_d = 1'b0;
    end
  end

  // scoreboard state
  typedef struct packed { logic [3:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t         exp_q [$];
  string       chk_name_q [$];
  logic [31:0] chk_act_q [$];
  logic [31:0] chk_exp_q [$];
  int compared = 0;
  int mismatched = 0;
  int hs_cnt = 0, done_cnt = 0, clr_cnt = 0, vld_cnt = 0, wr_cnt = 0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_x, prev_w;

  task automatic do_cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // monitor: drains queued checks, scores result writes, checks operand hold
  always @(negedge clk) begin
    wr_t   e;
    string nm;
    while (chk_name_q.size() > 0) begin
      nm = chk_name_q.pop_front();
      do_cmp(nm, chk_act_q.pop_front(), chk_exp_q.pop_front());
    end
    if (reset) begin
      if (res_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          do_cmp("unexpected_write", 32'(res_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          do_cmp("res_addr", 32'(res_addr), 32'(e.addr));
          do_cmp("res_data", 32'(res_data), 32'(e.data));
        end
      end
      if (done) done_cnt++;
      if (mac_clr) clr_cnt++;
      if (op_vld) vld_cnt++;
      if (op_vld && op_ack) hs_cnt++;
      if (prev_hold && !abort) begin
        do_cmp("hold_vld", 32'(op_vld), 32'd1);
        do_cmp("hold_x", 32'(op_x), 32'(prev_x));
        do_cmp("hold_w", 32'(op_w), 32'(prev_w));
      end
      prev_hold = op_vld && !op_ack;
      prev_x = op_x;
      prev_w = op_w;
    end else begin
      prev_hold = 1'b0;
    end
  end

  // reference model: dot product of input vector and neuron weight row, modulo 2^DW
  function automatic logic [DW-1:0] ref_dot(input int nn);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < TP; i++) s = s + 16'(x_mem[i] * w_mem[nn*TP + i]);
    return s;
  endfunction

  int base_hs, base_done, base_clr, base_vld, base_wr;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_name_q.push_back(name);
    chk_act_q.push_back(act);
    chk_exp_q.push_back(exp);
  endtask

  task automatic snap();
    base_hs = hs_cnt; base_done = done_cnt; base_clr = clr_cnt;
    base_vld = vld_cnt; base_wr = wr_cnt;
  endtask

  task automatic push_exp(input int n);
    for (int nn = 0; nn < n; nn++) exp_q.push_back({4'(nn), ref_dot(nn)});
  endtask

  task automatic start_layer(input logic [4:0] n);
    start = 1'b1; n_nrn = n;
    tick();
    start = 1'b0; n_nrn = 5'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin tick(); k++; end
    expect_eq({tag, "_done_seen"}, 32'(done), 32'd1);
    expect_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_counts(input string tag, input int hs, input int dn, input int wr);
    expect_eq({tag, "_handshakes"}, 32'(hs_cnt - base_hs), 32'(hs));
    expect_eq({tag, "_done_pulses"}, 32'(done_cnt - base_done), 32'(dn));
    expect_eq({tag, "_writes"}, 32'(wr_cnt - base_wr), 32'(wr));
    expect_eq({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    expect_eq({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic mem_ramp();
    for (int i = 0; i < TP; i++) x_mem[i] = 16'(i + 1);
    for (int i = 0; i < 128; i++) w_mem[i] = 16'd1;
  endtask

  task automatic mem_const();
    for (int i = 0; i < TP; i++) x_mem[i] = 16'd2;
    for (int i = 0; i < 128; i++) w_mem[i] = 16'd3;
  endtask

  task automatic mem_rand();
    for (int i = 0; i < TP; i++) x_mem[i] = 16'($urandom);
    for (int i = 0; i < 128; i++) w_mem[i] = 16'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int seen;
    int n;
    reset = 1'b0; start = 1'b0; n_nrn = '0; abort = 1'b0;
    rdy_inj = 1'b0; ack_rand = 1'b0; drain_dly = 0; op_ack = 1'b1;
    mem_ramp();
    repeat (3) tick();
    expect_eq("rst_ctl", 32'({op_vld, mac_clr, res_we, busy, done}), 32'd0);
    expect_eq("rst_addr", 32'({x_addr, w_addr, res_addr}), 32'd0);
    expect_eq("rst_ops", {op_x, op_w}, 32'd0);
    expect_eq("rst_res", 32'(res_data), 32'd0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // two neurons, ramp inputs, unit weights: 36 each, ack tied high
    snap(); push_exp(2);
    start_layer(5'd2);
    wait_done("s1", 400);
    repeat (4) tick();
    check_counts("s1", 16, 1, 2);

    // empty layer: done two cycles after start, no MAC activity
    snap();
    start_layer(5'd0);
    expect_eq("empty_t1", 32'({done, busy}), 32'b01);
    tick();
    expect_eq("empty_t2", 32'({done, busy}), 32'b10);
    repeat (3) tick();
    expect_eq("empty_clr", 32'(clr_cnt - base_clr), 32'd0);
    expect_eq("empty_vld", 32'(vld_cnt - base_vld), 32'd0);
    expect_eq("empty_wr", 32'(wr_cnt - base_wr), 32'd0);
    expect_eq("empty_done", 32'(done_cnt - base_done), 32'd1);

    // one neuron, x=2 w=3 (48), random ack delay
    mem_const(); ack_rand = 1'b1;
    snap(); push_exp(1);
    start_layer(5'd1);
    wait_done("s2", 600);
    repeat (4) tick();
    check_counts("s2", 8, 1, 1);
    ack_rand = 1'b0;

    // abort in WAIT of neuron 1 tap 4, with ack also present
    mem_ramp();
    snap(); push_exp(1);
    start_layer(5'd2);
    k = 0;
    while (!(op_vld && w_addr == 7'h0C) && k < 300) begin tick(); k++; end
    expect_eq("abort_reach_n1t4", 32'(w_addr), 32'h0C);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    expect_eq("abort_next", 32'({op_vld, mac_clr, res_we, done}), 32'b0100);
    tick();
    expect_eq("abort_done", 32'({done, busy}), 32'b10);
    repeat (3) tick();
    expect_eq("abort_writes", 32'(wr_cnt - base_wr), 32'd1);
    expect_eq("abort_pending", 32'(exp_q.size()), 32'd0);
    snap(); push_exp(2);
    start_layer(5'd2);
    wait_done("rerun", 400);
    repeat (4) tick();
    check_counts("rerun", 16, 1, 2);

    // start re-pulsed while busy and mac_rdy glitched during WAIT: both ignored
    snap(); push_exp(2);
    start_layer(5'd2);
    seen = 0; k = 0;
    while (seen < 3 && k < 300) begin tick(); k++; if (op_vld) seen++; end
    start = 1'b1; n_nrn = 5'd5; rdy_inj = 1'b1;
    tick();
    start = 1'b0; rdy_inj = 1'b0;
    wait_done("glitch", 400);
    repeat (4) tick();
    check_counts("glitch", 16, 1, 2);

    // random layers, random ack; last one is the full 16-neuron layer
    ack_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      mem_rand();
      n = (r == 2) ? 16 : int'($urandom_range(1, 5));
      snap(); push_exp(n);
      start_layer(5'(n));
      wait_done("rand", 5000);
      repeat (4) tick();
      check_counts("rand", 8 * n, 1, n);
    end
    ack_rand = 1'b0;

    // reset in DRAIN: outputs clear at once, no done and no write afterwards
    drain_dly = 6;
    snap();
    start_layer(5'd1);
    k = 0;
    while ((hs_cnt - base_hs) < 8 && k < 200) begin tick(); k++; end
    repeat (2) tick();
    expect_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    expect_eq("mid_rst_ctl", 32'({op_vld, mac_clr, res_we, busy, done}), 32'd0);
    expect_eq("mid_rst_addr", 32'({x_addr, w_addr, res_addr}), 32'd0);
    expect_eq("mid_rst_ops", {op_x, op_w}, 32'd0);
    tick();
    reset = 1'b1;
    repeat (8) tick();
    expect_eq("post_rst_busy", 32'(busy), 32'd0);
    expect_eq("post_rst_done", 32'(done_cnt - base_done), 32'd0);
    expect_eq("post_rst_wr", 32'(wr_cnt - base_wr), 32'd0);
    drain_dly = 0;

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
